bf_window_fetch: RTL and testbench

//  Upstream feeder for the bilateral filter core. Walks the 256x256 8-bit image in raster order through
//  the external pixel-memory port (in_addr -> in_data). Keeps WIN-1 previous rows in a line buffer.

---
 rtl/bf_pkg.sv | 43 ++++
 rtl/bf_line_buffer.sv | 26 ++
 rtl/bf_window_fetch.sv | 185 ++++++++++++++++++
 tb/tb_bf_window_fetch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared constants, FSM state type and column types for the bilateral-filter window fetcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bf_pkg;

   localparam int IMG_W = 256;
   localparam int IMG_H = 256;
   localparam int WIN   = 11;
   localparam int DW    = 8;
   localparam int AW    = 16;

   // Coordinate width on the column interface
   localparam int CW    = 8;
   // Number of stored previous rows, and width of a row-slot index
   localparam int unsigned NSLOT = WIN - 1;
   localparam int SW    = $clog2(NSLOT);
   localparam int NPIX  = IMG_W * IMG_H;
   localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      DONE
   } fetch_state_t;

   typedef logic [WIN*DW-1:0] col_t;

   typedef struct packed {
      col_t          dat;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
   } col_ent_t;

   // Row slot that lies ofs rows below base, modulo the number of slots
   function automatic logic [SW-1:0] slot_add(input logic [SW-1:0] base, input int unsigned ofs);
      int unsigned s;
      s = 32'(base) + ofs;
      if (s >= NSLOT) s = s - NSLOT;
      return s[SW-1:0];
   endfunction

endpackage

// File: rtl/bf_line_buffer.sv
// Line buffer holding the WIN-1 previous image rows, one slot per row, indexed by column x.
// Latency: combinational column read; write lands on the next rising edge (read-first).
// Backpressure: none; the caller writes at most one pixel per cycle.
module bf_line_buffer
   import bf_pkg::*;
(
   input  logic                  clk,
   input  logic [CW-1:0]         rd_x,
   output logic [NSLOT*DW-1:0]   rd_dat,
   input  logic                  wr_en,
   input  logic [SW-1:0]         wr_slot,
   input  logic [CW-1:0]         wr_x,
   input  logic [DW-1:0]         wr_dat
);

   // One word per column x; each word packs all row slots for that column
   logic [NSLOT*DW-1:0] mem [IMG_W];

   assign rd_dat = mem[rd_x];

   // Single-slot write; contents need no reset because rows 0..WIN-2 refill them each frame
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_x][wr_slot*DW +: DW] <= wr_dat;
   end

endmodule

// File: rtl/bf_window_fetch.sv
// Raster-order pixel fetcher producing one vertical WIN-pixel column per pixel for rows y >= WIN-1.
// Latency: 2 cycles from address issue to col_valid with an empty skid FIFO and col_ready high.
// Backpressure: col_ready low holds col_*; a 2-credit scheme stops issue before the skid FIFO can overflow.
module bf_window_fetch
   import bf_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic [AW-1:0]       in_addr,
   input  logic [DW-1:0]       in_data,
   output logic                col_valid,
   input  logic                col_ready,
   output logic [WIN*DW-1:0]   col_data,
   output logic [CW-1:0]       col_x,
   output logic [CW-1:0]       col_y,
   output logic                frame_done
);

   fetch_state_t state_q, state_d;

   // Coordinates and row slot of the address currently on in_addr
   logic [CW-1:0] iss_x, iss_y;
   logic [SW-1:0] iss_slot;

   // Fetch in flight: its data arrives on in_data during the following cycle
   logic          pend_vld;
   logic [CW-1:0] pend_x, pend_y;
   logic [SW-1:0] pend_slot;

   // Skid FIFO
   col_ent_t      fifo_mem [2];
   logic          wr_ptr, rd_ptr;
   logic [1:0]    occ;

   logic          issue, last_issue;
   logic [1:0]    in_flight;
   logic          load_out, cap_col, push, pop;
   logic [NSLOT*DW-1:0] lb_rd;
   col_t          cap_dat;
   col_ent_t      cap_ent, head_ent;

   assign in_flight  = {1'b0, pend_vld} + occ;
   assign frame_done = (state_q == DONE);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next state and issue decision; issue needs a free credit out of two
   always_comb begin
      state_d    = state_q;
      issue      = 1'b0;
      last_issue = 1'b0;
      case (state_q)
         IDLE:  if (in_valid) state_d = FETCH;
         FETCH: begin
            issue      = in_valid && (in_flight < 2'd2);
            last_issue = issue && (in_addr == LAST_ADDR);
            if (last_issue) state_d = DRAIN;
         end
         DRAIN: if (!pend_vld && (occ == 2'd0) && col_valid && col_ready) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Address and coordinate counters; the last address is held until the frame closes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_addr  <= '0;
         iss_x    <= '0;
         iss_y    <= '0;
         iss_slot <= '0;
      end else if (state_q == DONE) begin
         in_addr  <= '0;
         iss_x    <= '0;
         iss_y    <= '0;
         iss_slot <= '0;
      end else if (issue && !last_issue) begin
         in_addr <= in_addr + 1'b1;
         if (iss_x == CW'(IMG_W - 1)) begin
            iss_x    <= '0;
            iss_y    <= iss_y + 1'b1;
            iss_slot <= (iss_slot == SW'(NSLOT - 1)) ? '0 : iss_slot + 1'b1;
         end else begin
            iss_x <= iss_x + 1'b1;
         end
      end
   end

   // Remember what was issued so the returning pixel can be placed
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_vld  <= 1'b0;
         pend_x    <= '0;
         pend_y    <= '0;
         pend_slot <= '0;
      end else begin
         pend_vld <= issue;
         if (issue) begin
            pend_x    <= iss_x;
            pend_y    <= iss_y;
            pend_slot <= iss_slot;
         end
      end
   end

   bf_line_buffer u_line_buffer (
      .clk     (clk),
      .rd_x    (pend_x),
      .rd_dat  (lb_rd),
      .wr_en   (pend_vld),
      .wr_slot (pend_slot),
      .wr_x    (pend_x),
      .wr_dat  (in_data)
   );

   // Column assembly: the slot about to be overwritten holds the oldest row, so it goes on top
   always_comb begin
      cap_dat = '0;
      for (int unsigned k = 0; k < NSLOT; k++) begin
         cap_dat[k*DW +: DW] = lb_rd[slot_add(pend_slot, k)*DW +: DW];
      end
      cap_dat[NSLOT*DW +: DW] = in_data;
      cap_ent.dat = cap_dat;
      cap_ent.x   = pend_x;
      cap_ent.y   = pend_y;
   end

   assign cap_col  = pend_vld && (pend_y >= CW'(NSLOT));
   assign load_out = !col_valid || col_ready;
   assign pop      = load_out && (occ != 2'd0);
   assign push     = cap_col && ((occ != 2'd0) || !load_out);
   assign head_ent = fifo_mem[rd_ptr];

   // Skid FIFO storage
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= cap_ent;
   end

   // Skid FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   // Output register: FIFO head has priority, otherwise a fresh column bypasses the FIFO
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_valid <= 1'b0;
         col_data  <= '0;
         col_x     <= '0;
         col_y     <= '0;
      end else if (load_out) begin
         if (pop) begin
            col_valid <= 1'b1;
            col_data  <= head_ent.dat;
            col_x     <= head_ent.x;
            col_y     <= head_ent.y;
         end else if (cap_col) begin
            col_valid <= 1'b1;
            col_data  <= cap_ent.dat;
            col_x     <= cap_ent.x;
            col_y     <= cap_ent.y;
         end else begin
            col_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bf_window_fetch.sv
// Scoreboard bench for bf_window_fetch: full ramp frame, stall hold, random backpressure, async reset restart.
// Latency: n/a.
// Backpressure: col_ready driven from a per-phase mode (always, random, held low).
module tb_bf_window_fetch;
   import bf_pkg::*;

   logic              clk, rst, in_valid, col_valid, col_ready, frame_done;
   logic [AW-1:0]     in_addr;
   logic [DW-1:0]     in_data;
   logic [WIN*DW-1:0] col_data;
   logic [7:0]        col_x, col_y;

   typedef struct {
      logic [WIN*DW-1:0] d;
      logic [7:0]        x;
      logic [7:0]        y;
   } exp_t;

   exp_t sb_q[$];

   int total = 0;
   int bad = 0;
   int cols_seen = 0;
   int fd_count = 0;
   int img_sel = 0;
   int rdy_mode = 0;
   int iv_mode = 0;
   logic last_acc = 1'b0;
   logic [AW-1:0] addr_lat = '0;

   bf_window_fetch dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_addr    (in_addr),
      .in_data    (in_data),
      .col_valid  (col_valid),
      .col_ready  (col_ready),
      .col_data   (col_data),
      .col_x      (col_x),
      .col_y      (col_y),
      .frame_done (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] pix(input int sel, input int x, input int y);
      int v;
      v = (sel == 0) ? (x + 3*y) : (7*x + 13*y + 5);
      return v[7:0];
   endfunction

   task automatic push_frame(input int sel);
      exp_t e;
      for (int y = WIN-1; y < IMG_H; y++) begin
         for (int x = 0; x < IMG_W; x++) begin
            for (int k = 0; k < WIN; k++) e.d[k*DW +: DW] = pix(sel, x, y - (WIN-1) + k);
            e.x = 8'(x);
            e.y = 8'(y);
            sb_q.push_back(e);
         end
      end
   endtask

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Memory model and input drivers: data for the address seen in a cycle is presented the next cycle
   initial begin
      in_valid  = 1'b0;
      col_ready = 1'b0;
      in_data   = '0;
      forever begin
         @(negedge clk);
         addr_lat = in_addr;
         @(posedge clk);
         #1;
         in_data = pix(img_sel, int'(addr_lat) % IMG_W, int'(addr_lat) / IMG_W);
         case (rdy_mode)
            0:       col_ready = 1'b1;
            1:       col_ready = ($urandom_range(0, 1) == 1);
            default: col_ready = 1'b0;
         endcase
         case (iv_mode)
            0:       in_valid = 1'b0;
            1:       in_valid = 1'b1;
            default: in_valid = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: pops the scoreboard on each transfer and checks frame_done follows the last accept
   always @(negedge clk) begin
      logic acc_last;
      exp_t e;
      acc_last = 1'b0;
      if (rst) begin
         if (last_acc || frame_done) begin
            total++;
            if (frame_done !== last_acc) begin
               bad++;
               $display("FAIL frame_done_timing got=%0b want=%0b", frame_done, last_acc);
            end
         end
         if (frame_done) fd_count++;
         if (col_valid && col_ready) begin
            cols_seen++;
            total++;
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL column_extra got x=%0d y=%0d want none", col_x, col_y);
            end else begin
               e = sb_q.pop_front();
               if (col_data !== e.d || col_x !== e.x || col_y !== e.y) begin
                  bad++;
                  $display("FAIL column got x=%0d y=%0d d=%h want x=%0d y=%0d d=%h",
                           col_x, col_y, col_data, e.x, e.y, e.d);
               end
            end
            if (col_x == 8'd255 && col_y == 8'd255) acc_last = 1'b1;
            if (img_sel == 0 && col_x == 8'd0 && col_y == 8'd11) begin
               total++;
               if (col_data[DW-1:0] !== 8'd3) begin
                  bad++;
                  $display("FAIL row_wrap_top got=%0d want=3", col_data[DW-1:0]);
               end
            end
         end
      end
      last_acc = acc_last;
   end

   initial begin
      int t_iss, t_col, a0, a1, c0;
      exp_t hold;

      // Reset held with the memory port enabled
      rst = 1'b1;
      iv_mode = 1;
      rdy_mode = 0;
      #2 rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check("reset_addr", in_addr, 0);
         check("reset_valid", col_valid, 0);
         check("reset_done", frame_done, 0);
      end

      // Frame A: ramp image at full throughput
      img_sel = 0;
      push_frame(0);
      cols_seen = 0;
      fd_count = 0;
      @(negedge clk);
      rst = 1'b1;
      t_iss = -1;
      t_col = -1;
      for (int c = 0; c < 4000 && t_col < 0; c++) begin
         @(negedge clk);
         if (in_addr == 16'd2560 && t_iss < 0) t_iss = c;
         if (col_valid) t_col = c;
      end
      check("first_col_seen", (t_iss >= 0 && t_col >= 0), 1);
      check("first_col_latency", t_col - t_iss, 2);
      check("first_col_x", col_x, 0);
      check("first_col_y", col_y, 10);
      check("first_col_top", col_data[DW-1:0], 0);
      check("first_col_bottom", col_data[DW*(WIN-1) +: DW], 30);

      // Stall hold for 5 cycles mid-frame
      for (int c = 0; c < 3000 && in_addr < 16'd3400; c++) @(negedge clk);
      @(posedge clk);
      rdy_mode = 2;
      @(negedge clk);
      a0 = int'(in_addr);
      if (sb_q.size() > 0) hold = sb_q[0];
      check("stall_queue", (sb_q.size() > 0), 1);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", col_valid, 1);
         check("stall_data", col_data, hold.d);
         check("stall_x", col_x, hold.x);
         check("stall_y", col_y, hold.y);
         @(negedge clk);
      end
      a1 = int'(in_addr);
      check("stall_issue_bound", (a1 - a0 <= 1), 1);
      c0 = cols_seen;
      rdy_mode = 0;
      repeat (2) @(negedge clk);
      check("stall_release", (cols_seen >= c0 + 1), 1);

      // Rest of frame A
      for (int c = 0; c < 70000 && !frame_done; c++) @(negedge clk);
      check("frame_done_seen", frame_done, 1);
      iv_mode = 0;
      @(negedge clk);
      check("addr_after_done", in_addr, 0);
      repeat (4) @(negedge clk);
      check("cols_per_frame", cols_seen, 62976);
      check("frame_done_pulses", fd_count, 1);
      check("scoreboard_empty", sb_q.size(), 0);
      check("idle_valid", col_valid, 0);

      // Frame B: random backpressure and in_valid pauses, then async reset between edges
      cols_seen = 0;
      push_frame(0);
      rdy_mode = 1;
      iv_mode = 2;
      for (int c = 0; c < 30000 && in_addr < 16'd2900; c++) @(negedge clk);
      check("reset_point_reached", (in_addr >= 16'd2900), 1);
      check("bp_cols_checked", (cols_seen > 0), 1);
      #2 rst = 1'b0;
      #1;
      check("async_addr", in_addr, 0);
      check("async_valid", col_valid, 0);
      check("async_x", col_x, 0);
      check("async_y", col_y, 0);
      check("async_data", col_data, 0);
      check("async_done", frame_done, 0);
      sb_q.delete();
      repeat (3) @(negedge clk);

      // Frame C: different image after reset; stale line-buffer data must not leak
      img_sel = 1;
      push_frame(1);
      cols_seen = 0;
      rdy_mode = 0;
      iv_mode = 1;
      rst = 1'b1;
      for (int c = 0; c < 6000 && cols_seen < 600; c++) @(negedge clk);
      check("restart_cols", (cols_seen >= 600), 1);
      iv_mode = 0;
      rst = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
